// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the linear-search sequencer states.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_DONE
  } search_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; zero flag reflects the current result.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    result = '0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/linear_search_ctrl.sv
// Scans memory from base_addr for key using the shared ALU's subtract/zero flag;
// reports the first matching offset with a one-cycle done pulse.
module linear_search_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] index
);

  search_state_e state_q, state_d;

  logic [DATA_W-1:0] key_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;   // one bit wider than an address so a full 2^ADDR_W scan terminates
  logic [ADDR_W-1:0] addr_q;
  logic              found_q;
  logic [ADDR_W-1:0] index_q;
  logic              last_elem;

  assign last_elem = (idx_q == len_q - (ADDR_W+1)'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (length == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_CMP;
      S_CMP:   state_d = (alu_zero || last_elem) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address wraps modulo 2^ADDR_W; it is held between fetches.
  always_comb begin
    mem_re      = (state_q == S_FETCH);
    mem_addr    = mem_re ? (base_q + idx_q[ADDR_W-1:0]) : addr_q;
    alu_control = ALU_SUB;
    alu_a       = (state_q == S_CMP) ? mem_rdata : '0;
    alu_b       = (state_q == S_CMP) ? key_q : '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
  end

  assign found = found_q;
  assign index = index_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      found_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= mem_addr;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            key_q   <= key;
            base_q  <= base_addr;
            len_q   <= length;
            idx_q   <= '0;
            found_q <= 1'b0;
            index_q <= '0;
          end
        end
        S_CMP: begin
          if (alu_zero) begin
            found_q <= 1'b1;
            index_q <= idx_q[ADDR_W-1:0];
          end else if (!last_elem) begin
            idx_q <= idx_q + (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_search_ctrl.sv
// Self-checking bench: real ALU plus one-cycle memory, checked against a
// loop-based reference search with expected latency and read trace.
module tb_linear_search_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] key;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]        alu_control;
  logic              alu_zero;
  logic              busy, done, found;
  logic [ADDR_W-1:0] index;

  logic [DATA_W-1:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu #(.DATA_W(DATA_W)) u_alu (
    .alu_control(alu_control),
    .a          (alu_a),
    .b          (alu_b),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  linear_search_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .base_addr  (base_addr),
    .length     (length),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .index      (index)
  );

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_search(input logic [31:0] k, input logic [7:0] b, input int n,
                            input bit poke, input string tag);
    logic [7:0] exp_reads[$];
    logic [7:0] got_reads[$];
    bit         exp_found = 0;
    int         exp_idx = 0;
    int         exp_cyc;
    int         cyc = 0;
    bit         seen = 0;
    int         mism = 0;

    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = 8'((int'(b) + i) % 256);
      exp_reads.push_back(a);
      if (mem[a] == k) begin
        exp_found = 1;
        exp_idx   = i;
        break;
      end
    end
    exp_cyc = exp_found ? 2 * exp_idx + 3 : (n == 0 ? 1 : 2 * n + 1);

    key = k; base_addr = b; length = 9'(n); start = 1'b1;
    @(posedge clk);
    while (!seen && cyc < exp_cyc + 8) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 2) begin
        start = 1'b1; key = ~k; base_addr = b + 8'd1; length = 9'd1;
      end
      if (mem_re) got_reads.push_back(mem_addr);
      if (done) seen = 1;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " found"}, 64'(found), 64'(exp_found));
    check({tag, " index"}, 64'(index), 64'(exp_idx));
    check({tag, " nreads"}, 64'(got_reads.size()), 64'(exp_reads.size()));
    foreach (exp_reads[i])
      if (i >= got_reads.size() || got_reads[i] != exp_reads[i]) mism++;
    check({tag, " read_addrs"}, 64'(mism), 64'd0);
    @(negedge clk);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " done_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key = '0; base_addr = '0; length = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'($urandom_range(100, 200));
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst found", 64'(found), 64'd0);
    check("rst index", 64'(index), 64'd0);
    check("rst mem_re", 64'(mem_re), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst alu_a", 64'(alu_a), 64'd0);
    check("rst alu_b", 64'(alu_b), 64'd0);
    check("rst alu_ctl", 64'(alu_control), 64'h6);
    reset = 1'b0;
    @(negedge clk);

    mem[8'h10] = 5; mem[8'h11] = 9; mem[8'h12] = 7; mem[8'h13] = 9; mem[8'h14] = 3;
    run_search(32'd9, 8'h10, 5, 1'b0, "hit1");
    run_search(32'd42, 8'h10, 5, 1'b0, "miss");
    run_search(32'd123, 8'h40, 0, 1'b0, "len0");

    mem[8'hFE] = 1; mem[8'hFF] = 2; mem[8'h00] = 3; mem[8'h01] = 32'hDEADBEEF;
    run_search(32'hDEADBEEF, 8'hFE, 4, 1'b0, "wrap");

    // Abort a search with reset after a successful one left found=1.
    run_search(32'd9, 8'h10, 5, 1'b0, "pre_rst");
    key = 32'd42; base_addr = 8'h10; length = 9'd5; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst found", 64'(found), 64'd0);
    check("midrst mem_re", 64'(mem_re), 64'd0);
    check("midrst mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b0;

    run_search(32'd9, 8'h10, 5, 1'b1, "busy_poke");

    mem[8'h30] = 32'h7FFFFFFF;
    run_search(32'h80000000, 8'h30, 1, 1'b0, "signbit");

    // Back-to-back: launch at the negedge right after done's follow-up check.
    key = 32'd7; base_addr = 8'h10; length = 9'd5; start = 1'b1;
    @(negedge clk);
    check("b2b busy", 64'(busy), 64'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 256; i++) mem[i] = 32'($urandom_range(0, 7));
    for (int t = 0; t < 40; t++) begin
      int n;
      n = (t == 7) ? 256 : int'($urandom_range(0, 14));
      run_search(32'($urandom_range(0, 9)), 8'($urandom), n, 1'b0,
                 $sformatf("rnd%0d", t));
    end
    mem[8'h55] = 32'hFFFF_FFFF;
    for (int i = 0; i < 256; i++) if (i != 8'h55) mem[i] = 32'd0;
    run_search(32'hFFFF_FFFF, 8'h56, 256, 1'b0, "full_last");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/linear_search_ctrl.md
Name: linear_search_ctrl

Overview:
Multi-cycle sequencer that drives the shared 32-bit ALU as its initiator, issuing subtract operations and consuming its zero flag. It scans a word-addressed data memory from a base address for a key and reports the first matching index. It sits between the top-level start/done interface and the data memory read port plus the ALU operand/control port.

Parameters:
DATA_W, 32, data word and ALU operand width
ADDR_W, 8, memory word-address width; index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; accepted only in IDLE
key  in  DATA_W  search value, latched on accepted start
base_addr  in  ADDR_W  first word address, latched on accepted start
length  in  ADDR_W+1  element count 0..2^ADDR_W, latched on accepted start
mem_addr  out  ADDR_W  memory read address
mem_re  out  1  read enable
mem_rdata  in  DATA_W  read data, valid the cycle after mem_re
alu_a  out  DATA_W  ALU operand a
alu_b  out  DATA_W  ALU operand b
alu_control  out  4  ALU opcode
alu_zero  in  1  ALU zero flag (combinational from alu_a/alu_b/alu_control)
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse
found  out  1  result valid with done; held until next accepted start
index  out  ADDR_W  matching offset from base_addr; held like found

Behaviour:
- Reset (synchronous, active-high; also mid-search): state IDLE; busy=0, done=0, found=0, index=0, mem_re=0, mem_addr=0, alu_a=0, alu_b=0, alu_control=4'b0110. Any search in progress is abandoned with no done pulse.
- States: IDLE, FETCH, CMP, DONE.
- IDLE, start=1:
  - latch key_q, base_q, len_q; clear idx and found/index.
  - length==0 -> DONE with found=0; otherwise -> FETCH.
  - start while not IDLE is ignored.
- FETCH:
  - mem_re=1, mem_addr = base_q+idx (modulo 2^ADDR_W, wraps silently) -> CMP.
- CMP:
  - mem_re=0; alu_a=mem_rdata, alu_b=key_q, alu_control=4'b0110 (subtract).
  - alu_zero=1 -> found=1, index=idx, go DONE.
  - else idx==len_q-1 -> found=0, index=0, go DONE.
  - else idx++ and go FETCH.
- DONE:
  - done=1 for exactly one cycle, busy=0 on the following cycle, -> IDLE.
  - A start in the cycle after DONE is accepted.
- busy=1 in FETCH, CMP and DONE.
- Outside CMP: alu_a=alu_b=0, alu_control=4'b0110; mem_addr holds its last value.
- Latency, counting the accept edge as cycle 0:
  - match at offset i: done high in cycle 2i+3.
  - no match, length n>0: done high in cycle 2n+1.
  - length 0: done high in cycle 1.
- Match rule: first (lowest) offset wins; later duplicates are not visited.
- length = 2^ADDR_W scans every address exactly once; the idx counter is ADDR_W+1 bits so termination never aliases.

Decomposition:
- Shared package cpu_pkg:
  - ALU opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_XOR=4'b0101, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - search state enum {S_IDLE, S_FETCH, S_CMP, S_DONE}.
- No sub-module inside this block. The ALU is instantiated alongside it at top level and connected by alu_a/alu_b/alu_control/alu_zero.
- The bench instantiates the real ALU plus a one-cycle-latency memory model.

Test Plan:
- Mem[0x10..0x14]={5,9,7,9,3}, base=0x10, length=5, key=9 -> done in cycle 5, found=1, index=1; only addresses 0x10,0x11 read.
- Same memory, key=42 -> done in cycle 11, found=0, index=0; addresses 0x10..0x14 each read once.
- length=0, key=anything -> done in cycle 1, found=0, mem_re never asserted.
- base=0xFE, length=4, mem[0x01]=0xDEADBEEF, key=0xDEADBEEF -> reads 0xFE,0xFF,0x00,0x01; found=1, index=3 (wrap).
- reset asserted in cycle 4 of a 5-element search -> next cycle busy=0, done=0, found=0; new start then completes normally. start pulsed while busy -> ignored, latched key unchanged.
- Key = 0x80000000 vs mem word 0x7FFFFFFF -> no false match (subtract nonzero). Back-to-back start in the cycle after done -> accepted and busy=1 in the next cycle.
